// File: rtl/pcw_video_pkg.sv
// Shared types, widths and address helpers for the PCW video line fetcher.
package pcw_video_pkg;

  localparam int unsigned BYTES_PER_LINE_DEFAULT = 90;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned BUF_AW = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LSB,
    RD_MSB,
    FETCH,
    DONE
  } fetch_state_e;

  // Roller RAM entry for a display line: page base plus two bytes per scrolled row.
  function automatic logic [ADDR_W-1:0] roller_entry(input logic [7:0] ptr,
                                                     input logic [7:0] line_y,
                                                     input logic [7:0] scroll);
    logic [7:0] row;
    row = line_y + scroll;
    return {ptr, 9'b0} + ADDR_W'({row, 1'b0});
  endfunction

  // Roller word to line base: bit 3 is forced low, bits above it shift up one place.
  function automatic logic [ADDR_W-1:0] line_base(input logic [15:0] rb);
    return {rb[15:3], 1'b0, rb[2:0]};
  endfunction

endpackage

// File: rtl/video_line_fetch_if.sv
// Memory read handshake between the line fetcher (master) and the memory arbiter (slave).
interface video_line_fetch_if;

  logic                              mem_req;
  logic [pcw_video_pkg::ADDR_W-1:0]  mem_addr;
  logic                              mem_ack;
  logic [pcw_video_pkg::DATA_W-1:0]  mem_din;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_din);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_din);

endinterface

// File: rtl/video_line_buf.sv
// Ping-pong line storage: 2 banks x 128 bytes, one sync write port, one sync read port.
module video_line_buf
  import pcw_video_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BUF_AW-1:0] rd_addr,
  input  logic              rd_zero,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] ram [2**BUF_AW];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_zero ? '0 : ram[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/video_line_fetch.sv
// Prefetches one display line per period via the roller RAM into a ping-pong line buffer.
module video_line_fetch
  import pcw_video_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE = BYTES_PER_LINE_DEFAULT
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                line_start,
  input  logic                fetch_en,
  input  logic [7:0]          fetch_y,
  input  logic [7:0]          roller_ptr,
  input  logic [7:0]          yscroll,
  video_line_fetch_if.master  mem,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data,
  output logic                line_ready,
  output logic                overrun
);

  fetch_state_e       state_q, state_d;
  logic               disp_sel_q, disp_sel_d;
  logic [1:0]         valid_q, valid_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [7:0]         lsb_q, lsb_d;
  logic [ADDR_W-1:0]  entry_q, entry_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               overrun_q, overrun_d;
  logic               line_ready_q, line_ready_d;

  logic [ADDR_W-1:0]  cur_addr_c;
  logic               wr_en_c;
  logic [BUF_AW-1:0]  wr_addr_c;
  logic               rd_zero_c;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      disp_sel_q   <= 1'b0;
      valid_q      <= '0;
      k_q          <= '0;
      lsb_q        <= '0;
      entry_q      <= '0;
      base_q       <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      overrun_q    <= 1'b0;
      line_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_sel_q   <= disp_sel_d;
      valid_q      <= valid_d;
      k_q          <= k_d;
      lsb_q        <= lsb_d;
      entry_q      <= entry_d;
      base_q       <= base_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      overrun_q    <= overrun_d;
      line_ready_q <= line_ready_d;
    end
  end

  always_comb begin
    unique case (state_q)
      RD_LSB:  cur_addr_c = entry_q;
      RD_MSB:  cur_addr_c = entry_q + ADDR_W'(1);
      default: cur_addr_c = base_q + ADDR_W'({k_q, 3'b000});
    endcase
  end

  // Next state; line_start overrides everything, including a coincident ack.
  always_comb begin
    state_d    = state_q;
    disp_sel_d = disp_sel_q;
    valid_d    = valid_q;
    k_d        = k_q;
    lsb_d      = lsb_q;
    entry_d    = entry_q;
    base_d     = base_q;
    req_d      = req_q;
    addr_d     = addr_q;
    overrun_d  = 1'b0;
    wr_en_c    = 1'b0;
    wr_addr_c  = {~disp_sel_q, k_q};

    if (line_start) begin
      overrun_d           = state_q inside {RD_LSB, RD_MSB, FETCH};
      disp_sel_d          = ~disp_sel_q;
      valid_d[disp_sel_q] = 1'b0;
      req_d               = 1'b0;
      k_d                 = '0;
      if (fetch_en) begin
        state_d = RD_LSB;
        entry_d = roller_entry(roller_ptr, fetch_y, yscroll);
      end else begin
        state_d = IDLE;
      end
    end else if (state_q inside {RD_LSB, RD_MSB, FETCH}) begin
      if (!req_q) begin
        req_d  = 1'b1;
        addr_d = cur_addr_c;
      end else if (mem.mem_ack) begin
        req_d = 1'b0;
        unique case (state_q)
          RD_LSB: begin
            lsb_d   = mem.mem_din;
            state_d = RD_MSB;
          end
          RD_MSB: begin
            base_d  = line_base({mem.mem_din, lsb_q});
            k_d     = '0;
            state_d = FETCH;
          end
          default: begin
            wr_en_c = 1'b1;
            if (k_q == IDX_W'(BYTES_PER_LINE - 1)) begin
              valid_d[~disp_sel_q] = 1'b1;
              state_d              = DONE;
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end
        endcase
      end
    end

    line_ready_d = valid_d[disp_sel_d];
  end

  assign rd_zero_c = !valid_q[disp_sel_q] || (32'(rd_idx) >= BYTES_PER_LINE);

  video_line_buf u_buf (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (mem.mem_din),
    .rd_addr ({disp_sel_q, rd_idx}),
    .rd_zero (rd_zero_c),
    .rd_data (rd_data)
  );

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign line_ready   = line_ready_q;
  assign overrun      = overrun_q;

endmodule
